// File: rtl/clk_manager.sv
// ---------------------------------------------------------------------------
// clk_manager
//
// Sits between the iCE40 PLL primitive and the rest of the design. It runs on
// the PLL reference clock, not on the PLL output. Its jobs are:
//   - sequence the PLL reset (RESETB is active-low)
//   - synchronise and filter the asynchronous LOCK signal
//   - hold the downstream design in reset until the PLL clock can be trusted
//   - detect lock loss, or accept a request, and re-sequence the PLL
//   - generate NUM_CH runtime-programmable clock-enable strobes
//
// Ports:
//   clk           in   reference clock
//   reset         in   synchronous, active-high
//   pll_lock      in   PLL LOCK, asynchronous
//   relock_req    in   single-cycle request to force a re-lock (RUN only)
//   div_cfg       in   channel i divisor at [i*DIV_WIDTH +: DIV_WIDTH]
//   pll_resetb    out  PLL RESETB, active-low
//   sys_reset     out  synchronous active-high reset for downstream logic
//   ready         out  high while in RUN
//   ch_en         out  per-channel one-cycle enable strobes
//   relock_count  out  saturating count of re-lock sequences since reset
// ---------------------------------------------------------------------------
module clk_manager #(
    parameter int NUM_CH              = 2,
    parameter int DIV_WIDTH           = 8,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_LOSS_FILTER    = 4,
    parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pll_lock,
    input  logic                        relock_req,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_cfg,
    output logic                        pll_resetb,
    output logic                        sys_reset,
    output logic                        ready,
    output logic [NUM_CH-1:0]           ch_en,
    output logic [7:0]                  relock_count
);

    // One timer serves both the PLL reset hold and the lock timeout. One
    // filter counter serves both the stable-lock count and the loss count.
    localparam int TIMER_MAX = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int FILT_MAX  = (LOCK_STABLE_CYCLES > LOCK_LOSS_FILTER) ?
                               LOCK_STABLE_CYCLES : LOCK_LOSS_FILTER;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int FILT_W    = $clog2(FILT_MAX + 1);

    // Each state advances on the edge where its counter would reach its
    // limit, so the compare is made against limit-1.
    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0]  STABLE_LAST  = FILT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [FILT_W-1:0]  LOSS_LAST    = FILT_W'(LOCK_LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [FILT_W-1:0]    filt_q, filt_d;
    logic                 sync1_q, sync1_d;
    logic                 lock_s_q, lock_s_d;
    logic [7:0]           relock_count_q, relock_count_d;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 sys_reset_q, sys_reset_d;
    logic                 ready_q, ready_d;
    logic                 relock_event;
    logic                 run_next;
    logic                 run_entry;

    // LOCK is meaningless while the PLL is held in reset, so the synchroniser
    // is flushed in PLL_RST. Lock qualification therefore always pays the
    // full two-flop latency after RESETB rises.
    always_comb begin
        sync1_d  = 1'b0;
        lock_s_d = 1'b0;
        if (state_q != ST_PLL_RST) begin
            sync1_d  = pll_lock;
            lock_s_d = sync1_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q + TIMER_W'(1);
        filt_d         = filt_q;
        relock_count_d = relock_count_q;
        relock_event   = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                filt_d = lock_s_q ? (filt_q + FILT_W'(1)) : '0;
                // A qualified lock wins over a timeout on the same edge.
                if (lock_s_q && (filt_q == STABLE_LAST)) begin
                    state_d = ST_RUN;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                filt_d  = lock_s_q ? '0 : (filt_q + FILT_W'(1));
                // Loss and request may coincide; it is a single re-lock.
                if ((!lock_s_q && (filt_q == LOSS_LAST)) || relock_req) begin
                    state_d      = ST_PLL_RST;
                    relock_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
            filt_d  = '0;
        end

        if (relock_event && (relock_count_q != 8'hFF)) begin
            relock_count_d = relock_count_q + 8'd1;
        end

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        pll_resetb_d = (state_d != ST_PLL_RST);
        sys_reset_d  = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    assign run_next  = (state_d == ST_RUN);
    assign run_entry = (state_q != ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_PLL_RST;
            timer_q        <= '0;
            filt_q         <= '0;
            sync1_q        <= 1'b0;
            lock_s_q       <= 1'b0;
            relock_count_q <= '0;
            pll_resetb_q   <= 1'b0;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            filt_q         <= filt_d;
            sync1_q        <= sync1_d;
            lock_s_q       <= lock_s_d;
            relock_count_q <= relock_count_d;
            pll_resetb_q   <= pll_resetb_d;
            sys_reset_q    <= sys_reset_d;
            ready_q        <= ready_d;
        end
    end

    assign pll_resetb   = pll_resetb_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_count_q;

    // Clock-enable dividers. cnt_q is the position of the current RUN cycle
    // within the divide period. The first RUN cycle always strobes; after
    // that a strobe fires when the previous position has reached the live
    // divisor, so lowering the divisor below the count wraps immediately.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_WIDTH-1:0] div_val;
            logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
            logic                 en_q, en_d;

            assign div_val = div_cfg[gi*DIV_WIDTH +: DIV_WIDTH];

            always_comb begin
                cnt_d = '0;
                en_d  = 1'b0;
                if (run_next) begin
                    if (run_entry || (cnt_q >= div_val)) begin
                        cnt_d = '0;
                        en_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    en_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    en_q  <= en_d;
                end
            end

            assign ch_en[gi] = en_q;
        end
    endgenerate

endmodule
